// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB completer register block
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

  localparam int          NUM_REGS   = 8;
  localparam logic [4:0]  OFF_REG6   = 5'h18;
  localparam logic [4:0]  OFF_ID     = 5'h1C;
  localparam logic [31:0] ID_DEFAULT = 32'hA9B0_0001;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - REG0..REG6 storage with byte-lane strobed writes
module apb_regfile
  import apb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [2:0]  idx_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] rdata_o,
  output logic [31:0] reg0_o
);

  logic [31:0] regs_q [NUM_REGS-1];
  logic [31:0] regs_d [NUM_REGS-1];

  always_comb begin
    regs_d  = regs_q;
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx_i == 3'(i)) begin
        rdata_o = regs_q[i];
        if (we_i) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_i[b]) regs_d[i][8*b +: 8] = wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign reg0_o = regs_q[0];

endmodule

// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB completer: wait-state FSM, decode and error checks
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic [31:0] ctrl_o
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;

  logic        xfer_err;
  logic        enter_ready;
  logic        rf_we;
  logic [31:0] rf_rdata;
  logic [31:0] rd_value;
  logic        unused_prot;

  assign unused_prot = ^PPROT[2:1];

  always_comb begin
    xfer_err = (|PADDR[31:5]) | (|PADDR[1:0])
             | (PWRITE & (PADDR[4:0] == OFF_ID))
             | (PWRITE & (PADDR[4:0] == OFF_REG6) & ~PPROT[0]);
    rd_value = (PADDR[4:0] == OFF_ID) ? ID_VALUE : rf_rdata;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    enter_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSELx && !PENABLE) begin
          if (ZERO_WAIT) begin
            enter_ready = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!PSELx) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (PENABLE) begin
          if (cnt_q == 4'd0) enter_ready = 1'b1;
          else               cnt_d = cnt_q - 4'd1;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Response is captured on entry so PREADY/PSLVERR/PRDATA are all flop outputs
    if (enter_ready) begin
      state_d   = ST_READY;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = xfer_err;
      prdata_d  = (!PWRITE && !xfer_err) ? rd_value : '0;
    end
  end

  assign rf_we = (state_q == ST_READY) && PSELx && PWRITE && !pslverr_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_regfile u_regfile (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we_i    (rf_we),
    .idx_i   (PADDR[4:2]),
    .wdata_i (PWDATA),
    .strb_i  (PSTRB),
    .rdata_o (rf_rdata),
    .reg0_o  (ctrl_o)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// tb/tb_apb_completer_regs.sv - self-checking bench for apb_completer_regs (WAIT_CYCLES 1 and 3)
module tb_apb_completer_regs;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  psel;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  logic        pready1, pslverr1, pready3, pslverr3;
  logic [31:0] prdata1, ctrl1, prdata3, ctrl3;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [2][7];

  always #5 PCLK = ~PCLK;

  apb_completer_regs #(.WAIT_CYCLES(1)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1), .ctrl_o(ctrl1)
  );

  apb_completer_regs #(.WAIT_CYCLES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3), .ctrl_o(ctrl3)
  );

  function automatic logic f_rdy(int d);      return (d == 0) ? pready1  : pready3;  endfunction
  function automatic logic f_err(int d);      return (d == 0) ? pslverr1 : pslverr3; endfunction
  function automatic logic [31:0] f_rd(int d);   return (d == 0) ? prdata1 : prdata3; endfunction
  function automatic logic [31:0] f_ctrl(int d); return (d == 0) ? ctrl1   : ctrl3;   endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_error(logic w, logic [31:0] a, logic [2:0] p);
    return (a[31:5] != 0) || (a[1:0] != 0) || (w && a[4:0] == 5'h1C)
        || (w && a[4:0] == 5'h18 && !p[0]);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 11);
    if (r < 8)       return {27'd0, 3'(r), 2'b00};
    else if (r < 10) return {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
    else             return {27'($urandom_range(1, 100)), 3'($urandom_range(0, 7)), 2'b00};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 7; i++) model[d][i] = '0;
  endtask

  // One complete transfer; the completer is left selected so a following call is back-to-back
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [2:0] p);
    int          lat;
    int          idx;
    logic        seen;
    logic        e_err;
    logic [31:0] e_rd;
    @(posedge PCLK); #1;
    check("ctrl_o", f_ctrl(d), model[d][0]);
    psel = '0; psel[d] = 1'b1; PENABLE = 1'b0;
    PWRITE = w; PADDR = a; PWDATA = wd; PSTRB = s; PPROT = p;
    idx   = int'(a[4:2]);
    e_err = exp_error(w, a, p);
    e_rd  = (w || e_err) ? 32'h0 : ((idx == 7) ? ID : model[d][idx]);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      @(negedge PCLK);
      if (f_rdy(d)) seen = 1'b1;
      else begin
        check("prdata_idle", f_rd(d), 32'h0);
        @(posedge PCLK); #1;
        lat++;
      end
    end
    check("latency", 32'(lat), (d == 0) ? 32'd2 : 32'd4);
    if (seen) begin
      check("pslverr", {31'd0, f_err(d)}, {31'd0, e_err});
      check("prdata", f_rd(d), e_rd);
      if (w && !e_err)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_pready"},  {31'd0, f_rdy(d)}, 32'h0);
      check({tag, "_pslverr"}, {31'd0, f_err(d)}, 32'h0);
      check({tag, "_prdata"},  f_rd(d),   32'h0);
      check({tag, "_ctrl"},    f_ctrl(d), 32'h0);
    end
  endtask

  initial begin
    PRESETn = 1'b0; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    clear_model();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_all_zero("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    xfer(0, 1'b1, 32'h00, 32'h1234_5678, 4'hF, 3'b000);
    go_idle();
    #1 check("ctrl_after_wr", ctrl1, 32'h1234_5678);

    xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'b000);
    xfer(0, 1'b1, 32'h04, 32'h0000_0000, 4'b0101, 3'b000);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    check("strobe_read", prdata1, 32'hFF00_FF00);

    xfer(0, 1'b1, 32'h1C, 32'hDEAD_BEEF, 4'hF, 3'b001);
    xfer(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3'b001);
    xfer(0, 1'b0, 32'h02, 32'h0, 4'h0, 3'b001);
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'hF, 3'b000);
    check("id_read", prdata1, ID);

    xfer(0, 1'b1, 32'h18, 32'h5555_AAAA, 4'hF, 3'b000);
    xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, 3'b000);
    xfer(0, 1'b1, 32'h18, 32'h5555_AAAA, 4'hF, 3'b001);
    xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, 3'b000);
    check("reg6_priv_wr", prdata1, 32'h5555_AAAA);
    go_idle();

    for (int n = 0; n < 80; n++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    // Abort: drop the select after one ACCESS cycle on the 3-wait instance
    @(posedge PCLK); #1;
    psel = 2'b10; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'hA5A5_0F0F;
    PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_access_rdy", {31'd0, pready3}, 32'h0);
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      check("abort_no_rdy", {31'd0, pready3}, 32'h0);
    end
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000);

    xfer(1, 1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, 3'b000);
    go_idle();
    #1 check("ctrl3_pre_reset", ctrl3, 32'hCAFE_F00D);

    // Reset in the middle of WAIT
    @(posedge PCLK); #1;
    psel = 2'b10; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h1111_2222;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    clear_model();
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    xfer(1, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hC, 3'b000);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_completer_regs.md
APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, shall set the number of ACCESS-phase wait cycles before PREADY (0..15).
REQ-002 Parameter ID_VALUE, default 32'hA9B0_0001, shall set the constant returned by the read-only ID register.
REQ-003 PCLK  in  1  single clock for the block; all logic on rising edge.
REQ-004 PRESETn  in  1  reset, asynchronous assertion, active-low.
REQ-005 PSELx  in  1  completer selected.
REQ-006 PENABLE  in  1  ACCESS phase indicator.
REQ-007 PWRITE  in  1  1 = write, 0 = read.
REQ-008 PADDR  in  32  byte address; bits [4:0] decoded.
REQ-009 PWDATA  in  32  write data.
REQ-010 PSTRB  in  4  byte-lane write strobes; PSTRB[n] covers PWDATA[8n+7:8n].
REQ-011 PPROT  in  3  protection; PPROT[0] = privileged.
REQ-012 PREADY  out  1  transfer completes this cycle.
REQ-013 PRDATA  out  32  read data, valid only when PREADY high on a read.
REQ-014 PSLVERR  out  1  transfer error, valid only when PREADY high.
REQ-015 ctrl_o  out  32  current value of REG0 for fabric use.

Function
REQ-016 Register map: offsets 0x00..0x18 shall be REG0..REG6 (read/write); 0x1C shall be ID (read-only, ID_VALUE).
REQ-017 FSM states IDLE, WAIT, READY; IDLE->WAIT on PSELx & !PENABLE when WAIT_CYCLES>0, IDLE->READY when WAIT_CYCLES=0.
REQ-018 On entering WAIT, a 4-bit counter shall load WAIT_CYCLES-1 and decrement each ACCESS cycle; WAIT->READY when counter is 0 and PENABLE high.
REQ-019 PREADY shall be registered and high for exactly one cycle (state READY); READY->IDLE unconditionally.
REQ-020 Setup at cycle T shall give PREADY at cycle T+1+WAIT_CYCLES.
REQ-021 PSLVERR shall assert with PREADY when PADDR[31:5] != 0, PADDR[1:0] != 0, write to 0x1C, or write to REG6 with PPROT[0]=0.
REQ-022 Write shall commit on the PREADY cycle only if PWRITE=1 and no error; only lanes with PSTRB[n]=1 update.
REQ-023 Errored writes shall leave all registers unchanged.
REQ-024 PRDATA shall carry the addressed register on a successful read PREADY cycle and 0 on all other cycles, including errored reads.
REQ-025 PSTRB!=0 on a read shall be ignored (no error, no update).
REQ-026 PSELx deasserted in WAIT shall abort: return to IDLE, no PREADY, no write.
REQ-027 Back-to-back transfers (new setup in the cycle after READY) shall be accepted with identical latency.

Reset
REQ-028 PRESETn low shall force, asynchronously: state IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0, REG0..REG6 0, ctrl_o 0.
REQ-029 Reset during WAIT or READY shall drop the transfer with no register update; first setup after release behaves normally.

Structure
REQ-030 Shared package apb_pkg shall hold the state enum, register offsets, NUM_REGS=8, and default ID constant.
REQ-031 Register storage and byte-strobe write logic shall be a sub-module apb_regfile; FSM, counter and decode live in the top.

Verification
REQ-032 WAIT_CYCLES=1: write 0x00 data 0x1234_5678 PSTRB=4'hF -> PREADY at T+2, PSLVERR 0, ctrl_o=0x1234_5678.
REQ-033 REG1=0xFFFF_FFFF, write 0x04 data 0 PSTRB=4'b0101 -> read 0x04 returns 0xFF00_FF00.
REQ-034 Write 0x1C, then write 0x40, then read 0x02 -> each PSLVERR=1, PRDATA 0, no register change; read 0x1C returns 0xA9B0_0001.
REQ-035 Write REG6 with PPROT=3'b000 -> PSLVERR=1, REG6 unchanged; PPROT=3'b001 -> write succeeds.
REQ-036 WAIT_CYCLES=3: drop PSELx after 1 ACCESS cycle -> no PREADY, no write; assert PRESETn low mid-WAIT -> all outputs 0 immediately.
